uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_tx_fifo.sv | 47 ++++
 rtl/uart_tx_engine.sv | 111 +++++++++++
 tb/tb_uart_tx_engine.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and framing constants for the UART transmitter
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
    localparam int DEFAULT_CLKS_PER_BIT = 447;
    localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two circular byte queue; a push into a full queue is only
// accepted when a pop frees the head slot in the same cycle
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = level_q == (AW+1)'(DEPTH);
    assign empty_o = level_q == '0;
    assign level_o = level_q;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;
    assign level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: bus-write synchronizer, transmit FIFO and 8N1 serializer with a
// registered line output and gap-free back-to-back frames
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_wr_async,
    input  logic [7:0]                    i_data,
    input  logic                          i_clr_overrun,
    output logic                          o_UART_RX,
    output logic                          o_full,
    output logic                          o_empty,
    output logic                          o_busy,
    output logic                          o_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         sync_q;
    logic               tx_q, tx_d, overrun_q, overrun_d;
    logic               push, pop, tick;
    logic [7:0]         head;

    // sync_q[1] is the synchronized request, sync_q[2] its previous value for edge detect
    assign push      = sync_q[1] && !sync_q[2] && !reset;
    assign tick      = cnt_q == LAST;
    assign o_UART_RX = tx_q;
    assign o_busy    = state_q != IDLE;
    assign o_overrun = overrun_q;
    assign overrun_d = (push && o_full && !pop) || (overrun_q && !i_clr_overrun);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .pop_i  (pop),
        .data_i (i_data),
        .data_o (head),
        .full_o (o_full),
        .empty_o(o_empty),
        .level_o(o_level)
    );

    // tx_d is computed alongside the transition so the line changes on the same edge as the state
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);
        unique case (state_q)
            IDLE: if (!o_empty) begin
                pop     = 1'b1;
                shift_d = head;
                state_d = START;
                tx_d    = 1'b0;
            end
            START: if (tick) begin
                state_d = DATA;
                bit_d   = '0;
                tx_d    = shift_q[0];
            end
            DATA: if (tick) begin
                if (bit_q == 3'(DATA_BITS - 1)) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    tx_d    = shift_q[1];
                end
            end
            STOP: if (tick) begin
                pop     = !o_empty;
                shift_d = o_empty ? shift_q : head;
                state_d = o_empty ? IDLE : START;
                tx_d    = o_empty;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            sync_q    <= '0;
            tx_q      <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            sync_q    <= {sync_q[1:0], i_wr_async};
            tx_q      <= tx_d;
            overrun_q <= overrun_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed checks of latency, framing, burst, overrun, full+pop,
// mid-frame reset and long write pulses with CLKS_PER_BIT=4, FIFO_DEPTH=4
module tb_uart_tx_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_wr_async = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_clr_overrun = 1'b0;
    logic       o_UART_RX, o_full, o_empty, o_busy, o_overrun;
    logic [2:0] o_level;
    int         n_chk = 0;
    int         n_fail = 0;
    int         lows;

    uart_tx_engine #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_wr_async   (i_wr_async),
        .i_data       (i_data),
        .i_clr_overrun(i_clr_overrun),
        .o_UART_RX    (o_UART_RX),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun),
        .o_level      (o_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] d, input int hold);
        i_data = d;
        i_wr_async = 1'b1;
        repeat (hold) @(negedge clk);
        i_wr_async = 1'b0;
    endtask

    // frame index k counts negedges from the first low start-bit sample; returns at k=40
    task automatic check_frame(input logic [7:0] b, input int cur);
        for (int k = cur; k < 40; k++) begin
            if (k == 0 || k == 2) chk($sformatf("start %02h", b), o_UART_RX, 0);
            else if (k >= 6 && k <= 34 && (k - 6) % 4 == 0)
                chk($sformatf("byte %02h bit%0d", b, (k - 6) / 4), o_UART_RX, b[(k - 6) / 4]);
            else if (k == 38) begin
                chk($sformatf("stop %02h", b), o_UART_RX, 1);
                chk($sformatf("busy %02h", b), o_busy, 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, " line"}, o_UART_RX, 1);
        chk({tag, " busy"}, o_busy, 0);
        chk({tag, " empty"}, o_empty, 1);
        chk({tag, " level"}, o_level, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        idle_chk("reset");
        chk("reset full", o_full, 0);
        chk("reset overrun", o_overrun, 0);
        reset = 1'b0;
        @(negedge clk);

        // single byte: push at t, pop at t+1, line low at t+2
        wr(8'hA5, 2);
        @(negedge clk);
        chk("lat line", o_UART_RX, 1);
        chk("lat level", o_level, 1);
        chk("lat empty", o_empty, 0);
        @(negedge clk);
        check_frame(8'hA5, 0);
        idle_chk("single end");

        // burst of three spaced writes
        for (int i = 0; i < 3; i++) begin
            wr(8'h01 + 8'(i), 2);
            @(negedge clk);
        end
        chk("burst level", o_level, 2);
        check_frame(8'h01, 5);
        check_frame(8'h02, 0);
        check_frame(8'h03, 0);
        idle_chk("burst end");

        // overrun: sixth write lands while four are queued
        for (int i = 0; i < 6; i++) begin
            wr(8'h10 + 8'(i), 2);
            @(negedge clk);
        end
        chk("ovr flag", o_overrun, 1);
        chk("ovr full", o_full, 1);
        chk("ovr level", o_level, 4);
        check_frame(8'h10, 14);
        for (int i = 1; i < 5; i++) check_frame(8'h10 + 8'(i), 0);
        idle_chk("ovr end");
        chk("ovr sticky", o_overrun, 1);
        i_clr_overrun = 1'b1;
        @(negedge clk);
        i_clr_overrun = 1'b0;
        chk("ovr cleared", o_overrun, 0);

        // full queue with a push landing on the STOP-end pop cycle
        for (int i = 0; i < 5; i++) begin
            wr(8'h20 + 8'(i), 2);
            @(negedge clk);
        end
        chk("fp full", o_full, 1);
        repeat (26) @(negedge clk);
        i_data = 8'h25;
        i_wr_async = 1'b1;
        repeat (2) @(negedge clk);
        chk("fp level pre", o_level, 4);
        i_wr_async = 1'b0;
        @(negedge clk);
        chk("fp level post", o_level, 4);
        chk("fp overrun", o_overrun, 0);
        for (int i = 1; i < 6; i++) check_frame(8'h20 + 8'(i), 0);
        idle_chk("fp end");

        // reset during DATA bit 3 with two bytes queued
        for (int i = 0; i < 3; i++) begin
            wr(8'h30 + 8'(i), 2);
            @(negedge clk);
        end
        chk("rst queued", o_level, 2);
        repeat (12) @(negedge clk);
        chk("rst bit3", o_UART_RX, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle_chk("rst abort");
        lows = 0;
        repeat (50) begin
            @(negedge clk);
            if (!o_UART_RX || o_busy) lows++;
        end
        chk("rst silent", lows, 0);

        // long write pulse yields one push
        i_data = 8'h40;
        i_wr_async = 1'b1;
        repeat (4) @(negedge clk);
        chk("long start", o_UART_RX, 0);
        repeat (16) @(negedge clk);
        i_wr_async = 1'b0;
        check_frame(8'h40, 16);
        idle_chk("long end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
